// File: rtl/bcd_digit_scanner_if.sv
// Bus between an RPM value source, the BCD digit scanner and the
// seven-segment decoder: load handshake plus the multiplexed digit outputs.
interface bcd_digit_scanner_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [3:0]        dec;
    logic [DIGITS-1:0] digit_sel;

    modport master (
        output load,
        output value,
        input  busy,
        input  done,
        input  ovf,
        input  dec,
        input  digit_sel
    );

    modport slave (
        input  load,
        input  value,
        output busy,
        output done,
        output ovf,
        output dec,
        output digit_sel
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a registered
// seven-segment decoder through a time-multiplexed digit scan. digit_sel is
// delayed one cycle past dec so it lines up with the decoder's segment output.
module bcd_digit_scanner #(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst,
    bcd_digit_scanner_if.slave bus
);

    // 10^n evaluated at elaboration time; 64 bits covers DIGITS up to 8.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned LIMIT = pow10(DIGITS) - 64'd1;
    localparam int POW_BITS = $clog2(pow10(DIGITS));
    localparam int CMP_W    = (POW_BITS > WIDTH) ? POW_BITS : WIDTH;
    // A value can only exceed 10^DIGITS-1 when WIDTH reaches log2(10^DIGITS).
    localparam bit CAN_OVF  = (WIDTH >= POW_BITS);
    localparam int BCD_W    = 4 * DIGITS;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W    = $clog2(SCAN_DIV);
    localparam int CNT_W    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       n;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            n = b[4*i +: 4];
            r[4*i +: 4] = (n >= 4'd5) ? (n + 4'd3) : n;
        end
        return r;
    endfunction

    // One double-dabble iteration on the BCD half: correct, then shift in the
    // next binary MSB. The operand is clamped, so no carry leaves the top nibble.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                     input logic             msb);
        logic [BCD_W-1:0] a;
        a = add3_all(b);
        return {a[BCD_W-2:0], msb};
    endfunction

    // One-hot decode of a scan index.
    function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] oh;
        for (int i = 0; i < DIGITS; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;
    logic              shift_s;
    logic              commit_s;
    logic [CMP_W-1:0]  value_ext_s;
    logic              over_s;

    logic [WIDTH-1:0]  bin_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_pend_r;
    logic [BCD_W-1:0]  disp_r;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;

    logic [PRE_W-1:0]  presc_r;
    logic [IDX_W-1:0]  idx_r;
    logic [3:0]        cur_digit_s;
    logic [DIGITS-1:0] lz_s;
    logic              zero_run_s;
    logic              blank_s;
    logic [3:0]        dec_r;
    logic [IDX_W-1:0]  idx_d_r;
    logic              blank_d_r;
    logic [DIGITS-1:0] sel_r;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion FSM next-state: idle -> WIDTH shift cycles -> one commit cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Conversion FSM control decode; loads arriving outside idle are dropped.
    always_comb begin
        accept_s = 1'b0;
        shift_s  = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE:   accept_s = bus.load;
            ST_SHIFT:  shift_s  = 1'b1;
            ST_COMMIT: commit_s = 1'b1;
            default: begin
                accept_s = 1'b0;
                shift_s  = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Range check of the incoming value against the largest displayable number.
    always_comb begin
        value_ext_s = CMP_W'(bus.value);
        if (CAN_OVF) begin
            over_s = (value_ext_s > CMP_W'(LIMIT));
        end else begin
            over_s = 1'b0;
        end
    end

    // Conversion datapath: capture/clamp, shift-add-3, atomic commit to display.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r      <= {WIDTH{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ovf_pend_r <= 1'b0;
            disp_r     <= {BCD_W{1'b0}};
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                bcd_r <= {BCD_W{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
                if (over_s) begin
                    bin_r      <= WIDTH'(LIMIT);
                    ovf_pend_r <= 1'b1;
                end else begin
                    bin_r      <= bus.value;
                    ovf_pend_r <= 1'b0;
                end
            end else if (shift_s) begin
                bcd_r <= dabble_step(bcd_r, bin_r[WIDTH-1]);
                bin_r <= {bin_r[WIDTH-2:0], 1'b0};
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                bcd_r <= bcd_r;
                bin_r <= bin_r;
                cnt_r <= cnt_r;
            end
            if (commit_s) begin
                disp_r <= bcd_r;
                ovf_r  <= ovf_pend_r;
            end else begin
                disp_r <= disp_r;
                ovf_r  <= ovf_r;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= commit_s;
        end
    end

    // Free-running scan prescaler and digit index (index 0 is the ones digit).
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PRE_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (presc_r == PRE_W'(SCAN_DIV - 1)) begin
            presc_r <= {PRE_W{1'b0}};
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Leading-zero map: lz_s[i] is set when displayed digits i..DIGITS-1 are all zero.
    always_comb begin
        lz_s       = {DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (disp_r[4*i +: 4] == 4'd0);
            lz_s[i]    = zero_run_s;
        end
    end

    // Current digit and blank decision for the active scan slot.
    always_comb begin
        cur_digit_s = disp_r[{idx_r, 2'b00} +: 4];
        if ((BLANK_LZ != 0) && (idx_r != {IDX_W{1'b0}})) begin
            blank_s = lz_s[idx_r];
        end else begin
            blank_s = 1'b0;
        end
    end

    // Output pipeline: dec one cycle after the index, digit_sel one cycle after dec.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_r     <= 4'd0;
            idx_d_r   <= {IDX_W{1'b0}};
            blank_d_r <= 1'b0;
            sel_r     <= {DIGITS{1'b0}};
        end else begin
            dec_r     <= cur_digit_s;
            idx_d_r   <= idx_r;
            blank_d_r <= blank_s;
            sel_r     <= onehot(idx_d_r) & ~{DIGITS{blank_d_r}};
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ovf       = ovf_r;
    assign bus.dec       = dec_r;
    assign bus.digit_sel = sel_r;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner (WIDTH=14, DIGITS=4, SCAN_DIV=4).
module tb_bcd_digit_scanner;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   k;

    bcd_digit_scanner_if #(.WIDTH(14), .DIGITS(4)) dut_if ();

    bcd_digit_scanner #(
        .WIDTH    (14),
        .DIGITS   (4),
        .SCAN_DIV (4),
        .BLANK_LZ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since the last reset edge; sets the expected scan phase.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic start_load(input string tag, input int v);
        dut_if.load  = 1'b1;
        dut_if.value = 14'(v);
        tick();
        dut_if.load  = 1'b0;
        check({tag, " busy after accept"}, 32'(dut_if.busy), 32'd1);
    endtask

    // Wait (bounded) for done; expect it exp_n cycles from now, with busy held.
    task automatic wait_done(input string tag, input int exp_n, input int exp_ovf);
        int n;
        bit seen;
        bit busy_bad;
        n = 0;
        seen = 1'b0;
        busy_bad = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (dut_if.done === 1'b1) seen = 1'b1;
            else if (dut_if.busy !== 1'b1) busy_bad = 1'b1;
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " done latency"}, 32'(n), 32'(exp_n));
        check({tag, " busy dropped early"}, 32'(busy_bad), 32'd0);
        check({tag, " busy at done"}, 32'(dut_if.busy), 32'd0);
        check({tag, " ovf"}, 32'(dut_if.ovf), 32'(exp_ovf));
        tick();
        check({tag, " done single pulse"}, 32'(dut_if.done), 32'd0);
    endtask

    // Check 16 scan cycles against the expected digits d0 (ones) .. d3.
    task automatic scan_check(input string tag, input int d0, input int d1,
                              input int d2, input int d3);
        int dg[4];
        int idx1;
        int idx2;
        bit blank;
        logic [3:0] exp_sel;
        dg[0] = d0;
        dg[1] = d1;
        dg[2] = d2;
        dg[3] = d3;
        tick();
        for (int c = 0; c < 16; c++) begin
            tick();
            idx1 = ((k - 1) / 4) % 4;
            idx2 = ((k - 2) / 4) % 4;
            blank = 1'b0;
            if (idx2 != 0) begin
                blank = 1'b1;
                for (int j = idx2; j < 4; j++) begin
                    if (dg[j] != 0) blank = 1'b0;
                end
            end
            exp_sel = blank ? 4'b0000 : (4'b0001 << idx2);
            check({tag, " dec"}, 32'(dut_if.dec), 32'(dg[idx1]));
            check({tag, " digit_sel"}, 32'(dut_if.digit_sel), 32'(exp_sel));
            check({tag, " no done"}, 32'(dut_if.done), 32'd0);
        end
    endtask

    initial begin
        int dn;
        int bz;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        dut_if.load  = 1'b0;
        dut_if.value = 14'd0;
        tick();
        tick();
        tick();
        check("reset busy", 32'(dut_if.busy), 32'd0);
        check("reset done", 32'(dut_if.done), 32'd0);
        check("reset ovf", 32'(dut_if.ovf), 32'd0);
        check("reset dec", 32'(dut_if.dec), 32'd0);
        check("reset digit_sel", 32'(dut_if.digit_sel), 32'd0);
        rst = 1'b0;

        start_load("v1234", 1234);
        wait_done("v1234", 15, 0);
        scan_check("v1234", 4, 3, 2, 1);

        start_load("v0", 0);
        wait_done("v0", 15, 0);
        scan_check("v0", 0, 0, 0, 0);

        start_load("v507", 507);
        wait_done("v507", 15, 0);
        scan_check("v507", 7, 0, 5, 0);

        start_load("v16383", 16383);
        wait_done("v16383", 15, 1);
        scan_check("v16383", 9, 9, 9, 9);

        start_load("v42", 42);
        wait_done("v42", 15, 0);
        scan_check("v42", 2, 4, 0, 0);

        // Second load while busy must be dropped.
        start_load("v1111", 1111);
        tick();
        tick();
        tick();
        tick();
        dut_if.load  = 1'b1;
        dut_if.value = 14'd2222;
        tick();
        dut_if.load  = 1'b0;
        wait_done("v1111", 10, 0);
        scan_check("v1111", 1, 1, 1, 1);

        start_load("v2222", 2222);
        wait_done("v2222", 15, 0);
        scan_check("v2222", 2, 2, 2, 2);

        // Reset in the middle of a conversion discards it.
        start_load("v9999rst", 9999);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 32'(dut_if.busy), 32'd0);
        check("midrst done", 32'(dut_if.done), 32'd0);
        check("midrst digit_sel", 32'(dut_if.digit_sel), 32'd0);
        check("midrst dec", 32'(dut_if.dec), 32'd0);
        dn = 0;
        bz = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut_if.done === 1'b1) dn++;
            if (dut_if.busy === 1'b1) bz++;
        end
        check("midrst done count", 32'(dn), 32'd0);
        check("midrst busy count", 32'(bz), 32'd0);
        scan_check("midrst", 0, 0, 0, 0);

        start_load("v8", 8);
        wait_done("v8", 15, 0);
        scan_check("v8", 8, 0, 0, 0);

        // Boundary values; 10000 is loaded in the cycle right after done.
        start_load("v9999", 9999);
        wait_done("v9999", 15, 0);
        start_load("v10000", 10000);
        wait_done("v10000", 15, 1);
        scan_check("v10000", 9, 9, 9, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
Upstream feeder for the registered 4-bit seven-segment decoder in the RPM display path. It accepts a binary RPM value on a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It time-multiplexes the BCD digits onto the decoder's 4-bit input and drives one-hot digit enables. Digit enables are delayed one cycle so they align with the decoder's registered segment output.

Parameters:
WIDTH, 14, bit width of the binary input value.
DIGITS, 4, number of display digits, 1..8.
SCAN_DIV, 1000, clock cycles each digit is held during scanning; must be >= 2.
BLANK_LZ, 1, 1 = suppress leading zeros; digit 0 is never blanked.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  single-cycle strobe; samples value.
value  input  WIDTH  binary value to display.
busy  output  1  conversion in progress.
done  output  1  one-cycle pulse when new digits take effect.
ovf  output  1  last accepted value exceeded 10^DIGITS-1.
dec  output  4  BCD digit to the decoder's dec input.
digit_sel  output  DIGITS  one-hot active-high digit enable, aligned with the decoder's seg output.

Behaviour:
- Reset: busy=0, done=0, ovf=0, dec=0, digit_sel=0, all stored and shadow digits=0, scan index=0, prescaler=0. Reset overrides everything else, including a conversion in flight. That conversion is discarded and the displayed digits return to 0.
- Accept rule: load is honoured only when busy=0. A load while busy=1 is ignored, with no queuing.
- Accept cycle (edge E):
  - If value > 10^DIGITS-1, the working value is clamped to 10^DIGITS-1 and the ovf register is set to 1. Otherwise ovf is set to 0. ovf updates at edge E+WIDTH+1 together with the digits.
  - busy goes to 1 at edge E.
- Conversion: exactly WIDTH shift iterations, one per cycle, at edges E+1..E+WIDTH.
  - Each iteration adds 3 to every BCD nibble >= 5, then left-shifts the {BCD, binary} register by 1.
  - The BCD shift register is 4*DIGITS bits wide. It is sufficient because the operand is already clamped.
- Commit (edge E+WIDTH+1):
  - Shadow digits copy into the displayed digit registers atomically.
  - busy=0, done=1 for exactly one cycle.
  - Displayed digits never show a partial conversion.
  - A load in the cycle right after done is accepted.
- Scan engine (free-running, independent of conversion):
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On each wrap, the scan index advances 0→1→…→DIGITS-1→0. Index 0 is the ones digit.
  - dec is registered: dec <= displayed_digit[index] every cycle, so dec follows an index change by 1 cycle.
  - digit_sel is registered once more than dec: digit_sel <= onehot(index of the previous cycle) & ~blank(previous cycle). This gives 2 cycles from index change to digit_sel, matching the decoder's 1-cycle latency on top of dec.
- Blanking (BLANK_LZ=1): the slot at index i>0 is blanked when displayed digits i..DIGITS-1 are all zero. A blanked slot drives digit_sel=0 for its whole period, while dec still carries 0. Value 0 shows a single "0" on digit 0.
- Digit change mid-scan: a commit takes effect on the next dec register update, with no scan restart.
- Width rules:
  - The comparison against 10^DIGITS-1 uses ceil(log2(10^DIGITS)) bits or WIDTH bits, whichever is larger.
  - If WIDTH is too narrow to exceed the limit, ovf is constant 0.

Test Plan:
- Reset, then load value=1234 (WIDTH=14, DIGITS=4, SCAN_DIV=4) → busy high for 15 cycles, done pulses once at E+15, ovf=0. dec sequence is 4,3,2,1 repeating, each held 4 cycles. digit_sel is 0001,0010,0100,1000, lagging dec by 1 cycle.
- Load value=0, BLANK_LZ=1 → dec cycles 0,0,0,0. digit_sel = 0001 in slot 0 and 0000 in slots 1-3. Load value=507 → digit 3 blanked, digits 0-2 show 7,0,5 with digit 1 enabled.
- Load value=16383 → ovf=1 after commit, all digits 9. A following load of 42 → ovf=0, digits 2,4 shown and upper two blanked.
- Load 1111, then load 2222 at E+5 while busy → second load ignored, digits 1111, single done pulse. Load 2222 again after done → digits 2222.
- Load 9999, assert rst at E+7 for one cycle → busy=0, done never pulses, digit_sel=0, display shows 0. A subsequent load of 8 → digits 8 after 15 cycles.
- Boundary: load 9999 → ovf=0, digits 9999. Load 10000 → ovf=1, digits 9999.
